rsa_cmd_master: RTL and testbench
=================================

RSA_CMD_MASTER -- requirements
Module: rsa_cmd_master

Interface
REQ-001 SHALL have parameters: X, default 3, PE rows; Y, default 3, PE columns; IN_LEN, default 8, argument/data word width; TO_CYC, default 255, drain timeout in cycles.
REQ-002 SHALL have ports: clk  in  1  clock; one clock only, all logic on the rising edge.
REQ-003 SHALL have ports: sys_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  single-cycle job request; busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse.
REQ-005 SHALL have ports: cmd_m, cmd_n, cmd_k  in  IN_LEN each  job dimensions; cmd_mode  in  2  job mode (0: m<X, 1: m>=X).
REQ-006 SHALL have ports: init_val  out  1; init_data  out  IN_LEN; init_rdy  in  1  (argument handshake to the array controller).
REQ-007 SHALL have ports: Xin_val, Yin_val  out  1 each; Xin_rdy, Yin_rdy  in  1 each  (operand stream handshake).
REQ-008 SHALL have ports: x_rd_addr, y_rd_addr  out  2*IN_LEN each  operand source-memory read addresses.
REQ-009 SHALL have ports: out_val  in  1; out_rdy  out  1; res_cnt  out  2*IN_LEN  result beats received; err  out  1  sticky error flag.

Function
REQ-010 SHALL implement the FSM states IDLE, ARGS, WAIT_RDY, STREAM, DRAIN and DONE.
REQ-011 In IDLE, start with init_rdy=1 and cmd_m, cmd_n, cmd_k all nonzero SHALL latch the cmd_* fields and the products m*n and n*k (2*IN_LEN bits, no overflow), then go to ARGS.
REQ-012 In IDLE, start with any dimension zero SHALL set err, stay in IDLE and pulse no done.
REQ-013 In IDLE, start with init_rdy=0 SHALL be ignored.
REQ-014 In ARGS, init_val SHALL be high for exactly 4 consecutive cycles with init_data = m, n, k, {0,mode} in that order, then go low.
REQ-015 init_val SHALL never drop mid-sequence, because the receiver closes the argument phase on the falling edge of init_val.
REQ-016 If init_rdy falls during ARGS, the module SHALL set err and still complete the 4-word sequence.
REQ-017 In WAIT_RDY, the FSM SHALL go to STREAM on the first cycle with Xin_rdy & Yin_rdy = 1.
REQ-018 In STREAM, Xin_val SHALL be high for exactly m*n contiguous cycles, with x_rd_addr running 0..m*n-1, one per cycle.
REQ-019 In STREAM, Yin_val SHALL be high for exactly n*k contiguous cycles, with y_rd_addr running 0..n*k-1; both streams SHALL start in the same cycle.
REQ-020 The FSM SHALL leave STREAM for DRAIN the cycle after the longer stream ends; each *_val SHALL deassert independently when its own count ends.
REQ-021 Address outputs SHALL hold 0 whenever the matching *_val is low.
REQ-022 In DRAIN, out_rdy SHALL be 1 and res_cnt SHALL increment on every cycle with out_val=1.
REQ-023 The FSM SHALL go from DRAIN to DONE on the first falling edge of out_val after at least one beat.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; res_cnt SHALL hold its value until the next accepted start.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-026 Latency from an accepted start to the first init_val SHALL be 1 cycle.

Reset
REQ-027 sys_rst SHALL force IDLE and drive 0 on every output (init_val, init_data, Xin_val, Yin_val, addresses, out_rdy, busy, done, res_cnt, err), overriding all other inputs.
REQ-028 Reset asserted mid-job SHALL abort the job with no done pulse; the first cycle after reset deasserts SHALL accept a new start.

Configuration
REQ-029 With RSA_CMD_TIMEOUT_EN defined, DRAIN SHALL count cycles without an out_val beat; reaching TO_CYC SHALL set err, pulse done and return to IDLE.
REQ-030 Without RSA_CMD_TIMEOUT_EN, DRAIN SHALL wait indefinitely and no timeout counter SHALL be synthesized.

Structure
REQ-031 The shared package rsa_pkg SHALL hold the FSM state encoding, the argument address constants (m=0, n=1, k=2, mode=3) and the mode constants MODE_0/MODE_1.
REQ-032 The single sub-module SHALL be rsa_stream_cnt, a loadable up-counter with val/addr outputs, instantiated twice (X stream and Y stream).

Verification
REQ-033 m=2,n=3,k=3,mode=0, init_rdy=1, all rdy=1 -> init_data 2,3,3,0 over 4 cycles; Xin_val 6 cycles; Yin_val 9 cycles; streams start together.
REQ-034 m=4,n=3,k=2,mode=1 -> Xin_val 12 cycles (x_rd_addr 0..11), Yin_val 6 cycles; Yin_val drops first; DRAIN entered after cycle 12.
REQ-035 out_val high 6 cycles then low -> res_cnt=6, done high exactly 1 cycle, busy low the next cycle.
REQ-036 start with cmd_k=0 -> err=1, no init_val; start while busy -> no effect.
REQ-037 sys_rst pulsed during STREAM -> all outputs 0 the next cycle; a following start runs a full clean job.
REQ-038 With RSA_CMD_TIMEOUT_EN and TO_CYC=16, out_val never asserted -> err=1 and done pulse 16 cycles after entering DRAIN.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA command master: FSM state encoding,
// argument word slots and job-mode constants.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARGS     = 3'd1,
        WAIT_RDY = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Order of the argument words sent to the array controller
    localparam logic [1:0] ARG_M    = 2'd0;
    localparam logic [1:0] ARG_N    = 2'd1;
    localparam logic [1:0] ARG_K    = 2'd2;
    localparam logic [1:0] ARG_MODE = 2'd3;

    // Job modes: MODE_0 when m < X, MODE_1 when m >= X
    localparam logic [1:0] MODE_0 = 2'd0;
    localparam logic [1:0] MODE_1 = 2'd1;

endpackage

// File: rtl/rsa_stream_cnt.sv
// Loadable up-counter driving one operand stream. A load starts a run of
// i_len consecutive cycles with o_val high and o_addr counting 0..i_len-1;
// o_last flags the final beat so the owner can plan its next state.
module rsa_stream_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    output logic         o_val,
    output logic [W-1:0] o_addr,
    output logic         o_last
);

    logic         r_act;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_last_idx;

    // run control: load arms the run, the last beat disarms it
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_act      <= 1'b0;
            r_cnt      <= '0;
            r_last_idx <= '0;
        end else if (i_load) begin
            r_act      <= (i_len != '0);
            r_cnt      <= '0;
            r_last_idx <= i_len - W'(1);
        end else if (r_act) begin
            if (r_cnt == r_last_idx) begin
                r_act <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_val  = r_act;
    assign o_addr = r_act ? r_cnt : '0;
    assign o_last = r_act && (r_cnt == r_last_idx);

endmodule

// File: rtl/rsa_cmd_master.sv
// Job sequencer for the systolic array: sends the m/n/k/mode argument
// words, streams X and Y operand addresses, then drains result beats.
// Optional drain timeout is enabled by defining RSA_CMD_TIMEOUT_EN.
module rsa_cmd_master
    import rsa_pkg::*;
#(
    parameter int X      = 3,
    parameter int Y      = 3,
    parameter int IN_LEN = 8,
    parameter int TO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [IN_LEN-1:0]     cmd_m,
    input  logic [IN_LEN-1:0]     cmd_n,
    input  logic [IN_LEN-1:0]     cmd_k,
    input  logic [1:0]            cmd_mode,
    output logic                  init_val,
    output logic [IN_LEN-1:0]     init_data,
    input  logic                  init_rdy,
    output logic                  Xin_val,
    output logic                  Yin_val,
    input  logic                  Xin_rdy,
    input  logic                  Yin_rdy,
    output logic [2*IN_LEN-1:0]   x_rd_addr,
    output logic [2*IN_LEN-1:0]   y_rd_addr,
    input  logic                  out_val,
    output logic                  out_rdy,
    output logic [2*IN_LEN-1:0]   res_cnt,
    output logic                  err
);

    localparam int AW = 2*IN_LEN;

    state_t            r_state, w_state_nxt;
    logic [IN_LEN-1:0] r_m, r_n, r_k;
    logic [1:0]        r_mode;
    logic [AW-1:0]     r_mn, r_nk;
    logic [1:0]        r_arg_idx;
    logic [AW-1:0]     r_res_cnt;
    logic              r_oval_d;
    logic              r_err;

    logic w_dims_ok, w_accept, w_zero_err, w_load, w_fall, w_timeout;
    logic w_x_last, w_y_last;

    assign w_dims_ok  = (cmd_m != '0) && (cmd_n != '0) && (cmd_k != '0);
    assign w_accept   = (r_state == IDLE) && start && init_rdy && w_dims_ok;
    assign w_zero_err = (r_state == IDLE) && start && init_rdy && !w_dims_ok;
    assign w_load     = (r_state == WAIT_RDY) && Xin_rdy && Yin_rdy;
    // falling edge of out_val inside DRAIN; r_oval_d only records DRAIN beats
    assign w_fall     = (r_state == DRAIN) && r_oval_d && !out_val;

`ifdef RSA_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] r_to_cnt;

    // count DRAIN cycles without a beat; any beat restarts the count
    always_ff @(posedge clk) begin
        if (sys_rst)
            r_to_cnt <= '0;
        else if (r_state != DRAIN || out_val)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign w_timeout = (r_state == DRAIN) && !out_val && (r_to_cnt == TW'(TO_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // latch the job fields and stream lengths on an accepted start
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_m    <= '0;
            r_n    <= '0;
            r_k    <= '0;
            r_mode <= '0;
            r_mn   <= '0;
            r_nk   <= '0;
        end else if (w_accept) begin
            r_m    <= cmd_m;
            r_n    <= cmd_n;
            r_k    <= cmd_k;
            r_mode <= cmd_mode;
            r_mn   <= AW'(cmd_m) * AW'(cmd_n);
            r_nk   <= AW'(cmd_n) * AW'(cmd_k);
        end
    end

    // argument word index, one word per ARGS cycle
    always_ff @(posedge clk) begin
        if (sys_rst || w_accept)
            r_arg_idx <= '0;
        else if (r_state == ARGS)
            r_arg_idx <= r_arg_idx + 2'd1;
    end

    // result beat counter, cleared only by a new job
    always_ff @(posedge clk) begin
        if (sys_rst || w_accept)
            r_res_cnt <= '0;
        else if (r_state == DRAIN && out_val)
            r_res_cnt <= r_res_cnt + AW'(1);
    end

    // previous-cycle DRAIN beat, for falling-edge detection
    always_ff @(posedge clk) begin
        if (sys_rst)
            r_oval_d <= 1'b0;
        else
            r_oval_d <= (r_state == DRAIN) && out_val;
    end

    // sticky error: bad dimensions, lost init_rdy during ARGS, drain timeout
    always_ff @(posedge clk) begin
        if (sys_rst)
            r_err <= 1'b0;
        else if (w_zero_err || (r_state == ARGS && !init_rdy) || w_timeout)
            r_err <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (sys_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        out_rdy     = 1'b0;
        init_val    = 1'b0;
        init_data   = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) w_state_nxt = ARGS;
            end
            ARGS: begin
                // all four words go out back to back; init_val never gaps
                init_val = 1'b1;
                case (r_arg_idx)
                    ARG_M:   init_data = r_m;
                    ARG_N:   init_data = r_n;
                    ARG_K:   init_data = r_k;
                    default: init_data = {{(IN_LEN-2){1'b0}}, r_mode};
                endcase
                if (r_arg_idx == ARG_MODE) w_state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (w_load) w_state_nxt = STREAM;
            end
            STREAM: begin
                // leave as soon as the longer stream is on its last beat
                if ((!Xin_val || w_x_last) && (!Yin_val || w_y_last))
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                out_rdy = 1'b1;
                if (w_fall || w_timeout) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    rsa_stream_cnt #(.W(AW)) u_x_cnt (
        .clk     (clk),
        .sys_rst (sys_rst),
        .i_load  (w_load),
        .i_len   (r_mn),
        .o_val   (Xin_val),
        .o_addr  (x_rd_addr),
        .o_last  (w_x_last)
    );

    rsa_stream_cnt #(.W(AW)) u_y_cnt (
        .clk     (clk),
        .sys_rst (sys_rst),
        .i_load  (w_load),
        .i_len   (r_nk),
        .o_val   (Yin_val),
        .o_addr  (y_rd_addr),
        .o_last  (w_y_last)
    );

    assign res_cnt = r_res_cnt;
    assign err     = r_err;

endmodule

// File: tb/tb_rsa_cmd_master.sv
// Directed + randomized bench for rsa_cmd_master. Expected traces come from
// the job arithmetic: 4 argument words, m*n and n*k stream beats with
// sequential addresses, drain count equal to the beats driven.
module tb_rsa_cmd_master;
    import rsa_pkg::*;

    localparam int IN_LEN = 8;
    localparam int TO_CYC = 16;
    localparam int AW     = 2*IN_LEN;

    logic              clk = 1'b0;
    logic              sys_rst, start, init_rdy, Xin_rdy, Yin_rdy, out_val;
    logic [IN_LEN-1:0] cmd_m, cmd_n, cmd_k;
    logic [1:0]        cmd_mode;
    logic              busy, done, init_val, Xin_val, Yin_val, out_rdy, err;
    logic [IN_LEN-1:0] init_data;
    logic [AW-1:0]     x_rd_addr, y_rd_addr, res_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic m_err = 1'b0;

    rsa_cmd_master #(.X(3), .Y(3), .IN_LEN(IN_LEN), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .busy(busy), .done(done),
        .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k), .cmd_mode(cmd_mode),
        .init_val(init_val), .init_data(init_data), .init_rdy(init_rdy),
        .Xin_val(Xin_val), .Yin_val(Yin_val), .Xin_rdy(Xin_rdy), .Yin_rdy(Yin_rdy),
        .x_rd_addr(x_rd_addr), .y_rd_addr(y_rd_addr),
        .out_val(out_val), .out_rdy(out_rdy), .res_cnt(res_cnt), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_ival"},  32'(init_val), 0);
        check({tag, "_idata"}, 32'(init_data), 0);
        check({tag, "_xval"},  32'(Xin_val), 0);
        check({tag, "_yval"},  32'(Yin_val), 0);
        check({tag, "_xaddr"}, 32'(x_rd_addr), 0);
        check({tag, "_yaddr"}, 32'(y_rd_addr), 0);
        check({tag, "_ordy"},  32'(out_rdy), 0);
        check({tag, "_rcnt"},  32'(res_cnt), 0);
        check({tag, "_err"},   32'(err), 0);
    endtask

    // One full job from the current negedge. nb = result beats (0 = let the
    // drain time out), abort_at = stream cycle at which reset is pulsed (-1 none).
    task automatic run_job(input int m, input int n, input int k, input int mode,
                           input int rdy_dly, input int nb, input bit drop_rdy,
                           input int abort_at, input bit busy_start);
        int mn, nk, len, gap;
        int words [4];
        mn = m * n;
        nk = n * k;
        len = (mn > nk) ? mn : nk;
        words = '{m, n, k, mode};
        cmd_m = IN_LEN'(m); cmd_n = IN_LEN'(n); cmd_k = IN_LEN'(k); cmd_mode = 2'(mode);
        start = 1'b1; init_rdy = 1'b1; Xin_rdy = 1'b0; Yin_rdy = 1'b0; out_val = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("args_val", 32'(init_val), 1);
            check("args_data", 32'(init_data), 32'(words[i]));
            check("args_busy", 32'(busy), 1);
            if (drop_rdy && i == 1) begin
                init_rdy = 1'b0;
                m_err = 1'b1;
            end
            tick();
        end
        init_rdy = 1'b1;
        check("args_end", 32'(init_val), 0);
        for (int d = 0; d < rdy_dly; d++) begin
            check("wait_xval", 32'(Xin_val), 0);
            check("wait_busy", 32'(busy), 1);
            tick();
        end
        Xin_rdy = 1'b1; Yin_rdy = 1'b1;
        tick();
        for (int i = 0; i <= len; i++) begin
            start = busy_start && (i == 1);
            if (busy_start && i == 1) cmd_k = '0;
            if (i == abort_at) begin
                sys_rst = 1'b1;
                tick();
                check_zero("abort");
                sys_rst = 1'b0; Xin_rdy = 1'b0; Yin_rdy = 1'b0; start = 1'b0;
                m_err = 1'b0;
                return;
            end
            check("xval", 32'(Xin_val), (i < mn) ? 1 : 0);
            check("xaddr", 32'(x_rd_addr), (i < mn) ? i : 0);
            check("yval", 32'(Yin_val), (i < nk) ? 1 : 0);
            check("yaddr", 32'(y_rd_addr), (i < nk) ? i : 0);
            check("stream_ordy", 32'(out_rdy), (i == len) ? 1 : 0);
            if (i < len) tick();
        end
        start = 1'b0;
`ifdef RSA_CMD_TIMEOUT_EN
        if (nb == 0) begin
            int t;
            t = 0;
            while (done !== 1'b1 && t < TO_CYC + 8) begin
                tick();
                t++;
            end
            m_err = 1'b1;
            check("to_latency", 32'(t), 32'(TO_CYC));
            check("to_err", 32'(err), 1);
            check("to_rcnt", 32'(res_cnt), 0);
            tick();
            check("to_idle", 32'(busy), 0);
            return;
        end
`endif
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            check("gap_ordy", 32'(out_rdy), 1);
            tick();
        end
        out_val = 1'b1;
        for (int b = 0; b < nb; b++) begin
            check("drain_ordy", 32'(out_rdy), 1);
            check("drain_cnt", 32'(res_cnt), 32'(b));
            check("drain_done", 32'(done), 0);
            tick();
        end
        out_val = 1'b0;
        check("fall_done", 32'(done), 0);
        tick();
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("done_rcnt", 32'(res_cnt), 32'(nb));
        check("done_err", 32'(err), 32'(m_err));
        tick();
        check("post_done", 32'(done), 0);
        check("post_busy", 32'(busy), 0);
        check("post_rcnt", 32'(res_cnt), 32'(nb));
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0; init_rdy = 1'b0; Xin_rdy = 1'b0; Yin_rdy = 1'b0;
        out_val = 1'b0; cmd_m = '0; cmd_n = '0; cmd_k = '0; cmd_mode = '0;
        @(negedge clk);
        start = 1'b1; init_rdy = 1'b1; cmd_m = 8'd1; cmd_n = 8'd1; cmd_k = 8'd1;
        tick();
        check_zero("reset");
        sys_rst = 1'b0; start = 1'b0;

        // directed jobs
        run_job(2, 3, 3, int'(MODE_0), 0, 6, 1'b0, -1, 1'b0);
        run_job(4, 3, 2, int'(MODE_1), 1, 6, 1'b0, -1, 1'b0);

        // zero dimension: error, no job
        cmd_m = 8'd2; cmd_n = 8'd2; cmd_k = 8'd0; init_rdy = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        m_err = 1'b1;
        check("zero_ival", 32'(init_val), 0);
        check("zero_busy", 32'(busy), 0);
        check("zero_err", 32'(err), 1);
        tick();
        check("zero_done", 32'(done), 0);

        // start without init_rdy is ignored
        cmd_k = 8'd2; init_rdy = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; init_rdy = 1'b1;
        check("nordy_busy", 32'(busy), 0);
        check("nordy_ival", 32'(init_val), 0);

        // start while busy, and init_rdy dropped during ARGS
        run_job(3, 2, 2, int'(MODE_1), 2, 4, 1'b0, -1, 1'b1);
        run_job(1, 2, 3, int'(MODE_0), 0, 2, 1'b1, -1, 1'b0);

        // reset mid-stream, then a clean job right after
        run_job(3, 4, 2, int'(MODE_1), 0, 3, 1'b0, 5, 1'b0);
        run_job(2, 2, 2, int'(MODE_0), 0, 5, 1'b0, -1, 1'b0);

        // randomized jobs
        for (int r = 0; r < 8; r++) begin
            int m, n, k;
            m = int'($urandom_range(1, 5));
            n = int'($urandom_range(1, 5));
            k = int'($urandom_range(1, 5));
            run_job(m, n, k, (m >= 3) ? int'(MODE_1) : int'(MODE_0),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 8)),
                    1'b0, -1, ($urandom_range(0, 1) == 1));
        end

`ifdef RSA_CMD_TIMEOUT_EN
        run_job(2, 2, 1, int'(MODE_0), 0, 0, 1'b0, -1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
